dbus_bridge: RTL and testbench
==============================

# dbus_bridge

Data-bus bridge sitting directly downstream of the memory-stage access controller. It turns the single-cycle pipeline data-bus request (enable, write, size, address, data) into a two-phase SRAM-like handshake (`req`/`addr_ok`, then `data_ok`). It stalls the pipeline until the transaction completes and returns the raw read word. Byte-lane placement, write strobes and alignment checks are also done here, so the external memory interface sees only word-addressed, strobed traffic.

## Interface
Parameters:
- `ADDR_W`, 32, address width (matches `W_ADDR`)
- `DATA_W`, 32, data width (matches `W_DATA`); the block is only defined for 32

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `dbus_en`  in  1  pipeline access request
- `dbus_we`  in  1  1 = store, 0 = load
- `dbus_size`  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
- `dbus_addr`  in  32  byte address
- `dbus_data`  in  32  store data, right-aligned in the low bits; ignored for loads
- `dbus_rdata`  out  32  raw aligned word returned by the load, valid in the cycle `dbus_stall` falls
- `dbus_stall`  out  1  hold the memory stage and everything upstream
- `dbus_adel`  out  1  misaligned load; no bus transaction is issued
- `dbus_ades`  out  1  misaligned store; no bus transaction is issued
- `data_req`  out  1  memory request valid
- `data_wr`  out  1  memory write
- `data_size`  out  2  copy of `dbus_size`
- `data_addr`  out  32  `dbus_addr` with bits [1:0] cleared
- `data_wdata`  out  32  lane-replicated store data
- `data_wstrb`  out  4  byte strobes; 0000 for loads
- `data_addr_ok`  in  1  request accepted this cycle
- `data_rdata`  in  32  read data, valid with `data_ok`
- `data_data_ok`  in  1  transaction complete

## Operation
- Misalignment rules:
  - Half access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]`≠0 is misaligned.
  - On misalignment, `dbus_adel` or `dbus_ades` is asserted combinationally while `dbus_en` is high.
  - No `data_req` is issued, there is no stall, and the FSM stays in IDLE.
- Store lanes:
  - Byte: data replicated ×4; strobe `0001<<addr[1:0]`.
  - Half: data replicated ×2; strobe `0011<<addr[1:0]`.
  - Word: data as-is; strobe `1111`.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - With `dbus_en` and an aligned request, `data_req`=1 combinationally.
  - If `addr_ok & data_ok`, go to DONE.
  - Else if `addr_ok`, go to DATA.
  - Else go to ADDR.
- ADDR:
  - `data_req`=1.
  - If `addr_ok & data_ok`, go to DONE.
  - Else if `addr_ok`, go to DATA.
  - `data_ok` without `addr_ok` is ignored.
- DATA:
  - `data_req`=0.
  - On `data_ok`, go to DONE.
- Read capture: when `data_ok` is taken (in IDLE, ADDR or DATA), `data_rdata` is captured into the rdata register. The capture happens for stores too; the value is then don't-care.
- DONE:
  - `dbus_stall`=0 and `data_req`=0.
  - `dbus_rdata` presents the captured word.
  - Always returns to IDLE. A new `dbus_en` in the following cycle starts a fresh transaction.
- Stall: `dbus_stall` = aligned `dbus_en` while state ≠ DONE. Upstream holds all `dbus_*` inputs stable while stalled.
- Pass-through: `data_*` request fields are driven combinationally from the held inputs.
- Transactions are never cancelled. Only reset aborts one.

## Timing
- Reset: state=IDLE, rdata register=0. All outputs are 0 while `rst_n`=0 and `dbus_en`=0.
- Best case (`addr_ok` and `data_ok` in request cycle 0):
  - DONE in cycle 1.
  - The stage is stalled 1 cycle, total 2 cycles.
- Typical (`addr_ok` in cycle 0, `data_ok` in cycle 1):
  - DONE in cycle 2.
  - Stalled cycles 0–1.
- Each extra wait cycle on either handshake adds exactly one stall cycle.
- Reset asserted mid-transaction: immediate return to IDLE and `data_req` drops asynchronously. A late `data_ok` after reset is ignored.
- Back-to-back requests: one idle bus cycle (the DONE state) between transactions.

## Structure
- Put these in `includes`: the `dbus_state_t` enum (IDLE/ADDR/DATA/DONE) and the size constants `SIZE_B`=00, `SIZE_H`=01, `SIZE_W`=10.
- Sub-module `dbus_lane` (purely combinational): size, address and data in; `wdata`, `wstrb` and misaligned flag out. The top level holds the FSM and the rdata register.

## Test plan
- Word load at 0x100, `addr_ok` cycle 0, `data_ok`+`data_rdata`=0xDEADBEEF cycle 1 -> stall in cycles 0–1, `dbus_rdata`=0xDEADBEEF with stall low in cycle 2, `data_addr`=0x100, `data_wstrb`=0000.
- Byte store 0xAB at 0x203, immediate `addr_ok`/`data_ok` -> `data_wdata`=0xABABABAB, `data_wstrb`=1000, `data_addr`=0x200, 1 stall cycle.
- Half store at 0x202 with `addr_ok` delayed 3 cycles, then `data_ok` 2 cycles later -> `data_req` high cycles 0–3, `wstrb`=1100, stall cycles 0–5.
- Word load at 0x102 -> `dbus_adel`=1, `data_req` never asserted, no stall; half store at 0x101 -> `dbus_ades`=1.
- `rst_n` pulled low while in DATA -> state IDLE, `data_req`=0, `dbus_stall` low once `dbus_en` is released; a subsequent load completes normally.
- Two consecutive word loads -> second `data_req` rises in the cycle after DONE, with exactly one bus-idle cycle between the transactions.

Source files
------------

// File: rtl/dbus_bridge_pkg.sv
// dbus_bridge_pkg: shared types and constants for the data-bus bridge.
//   dbus_state_t : bridge FSM states (IDLE/ADDR/DATA/DONE)
//   SIZE_*       : dbus_size encodings (11 is treated as word)
package dbus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } dbus_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/dbus_lane.sv
// dbus_lane: combinational byte-lane placement for the data-bus bridge.
//   size       in  access size (SIZE_B/H/W; 11 treated as word)
//   addr_lo    in  byte address bits [1:0]
//   data       in  right-aligned store data
//   wdata      out lane-replicated store data
//   wstrb      out byte strobes for the addressed lanes
//   misaligned out half on odd address, or word on non-zero addr_lo
module dbus_lane
  import dbus_bridge_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned
);

  // Replicating across lanes lets memory pick the addressed lane purely
  // from the strobes, with no shifter needed on the store path.
  always_comb begin
    wdata      = data;
    wstrb      = 4'b1111;
    misaligned = (addr_lo != 2'b00);
    case (size)
      SIZE_B: begin
        wdata      = {4{data[7:0]}};
        wstrb      = 4'b0001 << addr_lo;
        misaligned = 1'b0;
      end
      SIZE_H: begin
        wdata      = {2{data[15:0]}};
        wstrb      = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: pipeline data-bus request -> two-phase SRAM-like handshake.
//   clk, rst_n          clock, async active-low reset
//   dbus_*              pipeline side: en/we/size/addr/data in,
//                       rdata/stall/adel/ades out
//   data_req/wr/size/   memory request (word address, strobed data)
//   addr/wdata/wstrb
//   data_addr_ok        request accepted
//   data_data_ok/rdata  transaction complete with read data
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbus_en,
  input  logic              dbus_we,
  input  logic [1:0]        dbus_size,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_data,
  output logic [DATA_W-1:0] dbus_rdata,
  output logic              dbus_stall,
  output logic              dbus_adel,
  output logic              dbus_ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok
);

  logic [DATA_W-1:0] lane_wdata;
  logic [3:0]        lane_wstrb;
  logic              lane_mis;

  dbus_lane u_lane (
    .size       (dbus_size),
    .addr_lo    (dbus_addr[1:0]),
    .data       (dbus_data),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .misaligned (lane_mis)
  );

  dbus_state_t       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic aligned_req;
  logic addr_phase;

  assign aligned_req = dbus_en & ~lane_mis;
  // Request phase: a fresh aligned request in IDLE, or still waiting in ADDR.
  assign addr_phase  = (state_q == ADDR) | ((state_q == IDLE) & aligned_req);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, ADDR: begin
        if (addr_phase) begin
          // data_ok is only meaningful once the address has been accepted
          if (data_addr_ok & data_data_ok) begin
            state_d = DONE;
            rdata_d = data_rdata;
          end else if (data_addr_ok) begin
            state_d = DATA;
          end else begin
            state_d = ADDR;
          end
        end
      end
      DATA: begin
        if (data_data_ok) begin
          state_d = DONE;
          rdata_d = data_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // data_req is qualified by rst_n so an in-flight request drops the moment
  // reset asserts, even while upstream is still holding dbus_en.
  assign data_req   = rst_n & addr_phase;
  assign dbus_stall = aligned_req & (state_q != DONE);
  assign dbus_adel  = dbus_en & lane_mis & ~dbus_we;
  assign dbus_ades  = dbus_en & lane_mis & dbus_we;
  assign dbus_rdata = rdata_q;

  // Request fields follow the held inputs; zeroed when idle so the bus is quiet.
  assign data_wr    = dbus_en & dbus_we;
  assign data_size  = dbus_en ? dbus_size : 2'b00;
  assign data_addr  = dbus_en ? {dbus_addr[ADDR_W-1:2], 2'b00} : '0;
  assign data_wdata = (dbus_en & dbus_we) ? lane_wdata : '0;
  assign data_wstrb = (dbus_en & dbus_we) ? lane_wstrb : 4'b0000;

endmodule

// File: tb/tb_dbus_bridge.sv
module tb_dbus_bridge;

  logic        clk, rst_n;
  logic        dbus_en, dbus_we;
  logic [1:0]  dbus_size;
  logic [31:0] dbus_addr, dbus_data, dbus_rdata;
  logic        dbus_stall, dbus_adel, dbus_ades;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int checks = 0;
  int errors = 0;

  dbus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dbus_en      (dbus_en),
    .dbus_we      (dbus_we),
    .dbus_size    (dbus_size),
    .dbus_addr    (dbus_addr),
    .dbus_data    (dbus_data),
    .dbus_rdata   (dbus_rdata),
    .dbus_stall   (dbus_stall),
    .dbus_adel    (dbus_adel),
    .dbus_ades    (dbus_ades),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte count per size, lane i carries data byte (i mod n),
  // strobes cover lanes [lo, lo+n), misaligned when lo is not a multiple of n.
  function automatic void model(input logic [1:0] sz, input logic [31:0] addr,
                                input logic [31:0] data, output logic mis,
                                output logic [31:0] wd, output logic [3:0] st);
    int n;
    int lo;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lo = int'(addr[1:0]);
    mis = (lo % n) != 0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = data[8*(i%n) +: 8];
      st[i] = (i >= lo) && (i < lo + n);
    end
  endfunction

  task automatic idle_inputs();
    dbus_en = 0; dbus_we = 0; dbus_size = 0; dbus_addr = 0; dbus_data = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  // One aligned transaction: addr_ok after a wait cycles, data_ok d cycles later.
  // Expected: req in cycles 0..a, stall in cycles 0..a+d, DONE in a+d+1.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wdat, input int a, input int d,
                         input logic [31:0] rd, input string tag);
    logic mis;
    logic [31:0] ewd;
    logic [3:0] est;
    logic exp_stall, exp_req;
    model(sz, addr, wdat, mis, ewd, est);
    dbus_en = 1; dbus_we = we; dbus_size = sz; dbus_addr = addr; dbus_data = wdat;
    for (int c = 0; c <= a + d + 1; c++) begin
      data_addr_ok = (c == a);
      // spurious data_ok before acceptance must be ignored
      data_data_ok = (c == a + d) || ((c < a) && ($urandom_range(0, 2) == 0));
      data_rdata   = (c == a + d) ? rd : $urandom;
      @(negedge clk);
      exp_stall = (c <= a + d);
      exp_req   = (c <= a);
      checks++;
      if (dbus_stall !== exp_stall) begin
        errors++; $display("FAIL %s stall c=%0d got %b exp %b", tag, c, dbus_stall, exp_stall);
      end
      checks++;
      if (data_req !== exp_req) begin
        errors++; $display("FAIL %s data_req c=%0d got %b exp %b", tag, c, data_req, exp_req);
      end
      checks++;
      if (data_addr !== {addr[31:2], 2'b00}) begin
        errors++; $display("FAIL %s data_addr got %h exp %h", tag, data_addr, {addr[31:2], 2'b00});
      end
      checks++;
      if (data_wstrb !== (we ? est : 4'b0000) || data_wr !== we || data_size !== sz) begin
        errors++;
        $display("FAIL %s wstrb/wr/size got %b/%b/%b exp %b/%b/%b", tag, data_wstrb, data_wr,
                 data_size, (we ? est : 4'b0000), we, sz);
      end
      if (we) begin
        checks++;
        if (data_wdata !== ewd) begin
          errors++; $display("FAIL %s wdata got %h exp %h", tag, data_wdata, ewd);
        end
      end
      if (c == a + d + 1 && !we) begin
        checks++;
        if (dbus_rdata !== rd) begin
          errors++; $display("FAIL %s rdata got %h exp %h", tag, dbus_rdata, rd);
        end
      end
      @(posedge clk); #1;
    end
    data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic end_txn();
    dbus_en = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++;
    if ({data_req, dbus_stall, dbus_adel, dbus_ades, data_wr} !== 5'b0 ||
        dbus_rdata !== 32'h0 || data_addr !== 32'h0 || data_wdata !== 32'h0 ||
        data_wstrb !== 4'h0 || data_size !== 2'b00) begin
      errors++; $display("FAIL reset outputs req=%b stall=%b rdata=%h addr=%h",
                         data_req, dbus_stall, dbus_rdata, data_addr);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn(1'b0, 2'b10, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, "word_load");
    end_txn();
    run_txn(1'b1, 2'b00, 32'h203, 32'h000000AB, 0, 0, 32'h0, "byte_store");
    end_txn();
    run_txn(1'b1, 2'b01, 32'h202, 32'h00001234, 3, 2, 32'h0, "half_store");
    end_txn();
    run_txn(1'b0, 2'b11, 32'h3C, 32'h0, 1, 0, 32'h5555AAAA, "size11_load");
    end_txn();
  endtask

  task automatic check_misaligned(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                                  input string tag);
    dbus_en = 1; dbus_we = we; dbus_size = sz; dbus_addr = addr; dbus_data = $urandom;
    for (int c = 0; c < 3; c++) begin
      data_addr_ok = $urandom_range(0, 1);
      @(negedge clk);
      checks++;
      if (dbus_adel !== !we || dbus_ades !== we || data_req !== 1'b0 || dbus_stall !== 1'b0) begin
        errors++; $display("FAIL %s adel=%b ades=%b req=%b stall=%b exp adel=%b ades=%b req=0 stall=0",
                           tag, dbus_adel, dbus_ades, data_req, dbus_stall, !we, we);
      end
      @(posedge clk); #1;
    end
    data_addr_ok = 0;
    dbus_en = 0;
    #1;
    checks++;
    if (dbus_adel !== 1'b0 || dbus_ades !== 1'b0) begin
      errors++; $display("FAIL %s flags after release adel=%b ades=%b exp 0/0", tag, dbus_adel, dbus_ades);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    check_misaligned(1'b0, 2'b10, 32'h102, "mis_word_load");
    check_misaligned(1'b1, 2'b01, 32'h101, "mis_half_store");
    check_misaligned(1'b1, 2'b10, 32'h203, "mis_word_store");
    check_misaligned(1'b0, 2'b01, 32'h7, "mis_half_load");
    // FSM must still be in IDLE: a plain best-case load completes on time
    run_txn(1'b0, 2'b10, 32'h40, 32'h0, 0, 0, 32'h01234567, "after_mis");
    end_txn();
  endtask

  task automatic test_reset_mid();
    // reset while waiting in ADDR: data_req drops with en still held
    dbus_en = 1; dbus_we = 0; dbus_size = 2'b10; dbus_addr = 32'h80;
    data_addr_ok = 0; data_data_ok = 0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (data_req !== 1'b1) begin
      errors++; $display("FAIL rst_addr req_before got %b exp 1", data_req);
    end
    rst_n = 0; #1;
    checks++;
    if (data_req !== 1'b0) begin
      errors++; $display("FAIL rst_addr req_async got %b exp 0", data_req);
    end
    @(posedge clk); #1;
    rst_n = 1; dbus_en = 0;
    @(posedge clk); #1;
    // reset while in DATA
    dbus_en = 1; dbus_addr = 32'h84;
    data_addr_ok = 1;
    @(posedge clk); #1;
    data_addr_ok = 0;
    #2;
    rst_n = 0; #1;
    checks++;
    if (data_req !== 1'b0) begin
      errors++; $display("FAIL rst_data req got %b exp 0", data_req);
    end
    dbus_en = 0; #1;
    checks++;
    if (dbus_stall !== 1'b0 || dbus_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_data stall/rdata got %b/%h exp 0/0", dbus_stall, dbus_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1;
    // late data_ok after reset is ignored
    data_data_ok = 1; data_rdata = 32'hBADBAD00;
    @(negedge clk);
    checks++;
    if (dbus_stall !== 1'b0 || data_req !== 1'b0) begin
      errors++; $display("FAIL late_ok stall/req got %b/%b exp 0/0", dbus_stall, data_req);
    end
    @(posedge clk); #1;
    data_data_ok = 0;
    checks++;
    if (dbus_rdata !== 32'h0) begin
      errors++; $display("FAIL late_ok rdata got %h exp 0", dbus_rdata);
    end
    run_txn(1'b0, 2'b10, 32'h88, 32'h0, 1, 1, 32'hC0FFEE11, "after_rst");
    end_txn();
  endtask

  task automatic test_back_to_back();
    // second request is presented right after DONE; run_txn checks the
    // DONE cycle has req=0 and the next cycle has req=1
    run_txn(1'b0, 2'b10, 32'h300, 32'h0, 0, 1, 32'h11112222, "b2b_first");
    run_txn(1'b0, 2'b10, 32'h304, 32'h0, 0, 1, 32'h33334444, "b2b_second");
    end_txn();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic we;
      logic [1:0] sz;
      logic [31:0] addr;
      int n;
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      addr = $urandom;
      addr[1:0] = 2'(n * $urandom_range(0, (4 / n) - 1));
      run_txn(we, sz, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, "random");
      if ($urandom_range(0, 1) == 1) end_txn();
    end
    end_txn();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
